// File: rtl/input_vector_assembler.sv
// input_vector_assembler
// Packs a stream of BEAT_W-wide beats, LSB-first, into one VEC_W-bit snapshot.
// It checks the first/last framing and presents the finished vector with a
// valid/ready handshake. Any framing violation discards the partial vector and
// raises a registered one-cycle frame_err pulse.
module input_vector_assembler #(
  parameter int VEC_W  = 1894,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BEAT_W-1:0] in_data,
  input  logic              in_first,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [VEC_W-1:0]  vec_o,
  output logic              vec_valid,
  input  logic              vec_ready,
  output logic              frame_err,
  output logic [4:0]        beat_cnt
);

  // Beats per vector, and the width of the partially used final beat.
  localparam int         NBEATS   = (VEC_W + BEAT_W - 1) / BEAT_W;
  localparam int         LAST_W   = VEC_W - (NBEATS - 1) * BEAT_W;
  localparam logic [4:0] LAST_IDX = 5'(NBEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [4:0]                      r_beat_cnt;
  logic [4:0]                      w_beat_cnt_nxt;
  logic                            r_frame_err;
  logic                            w_frame_err_nxt;
  logic                            w_accept;
  logic                            w_wr_en;
  logic [4:0]                      w_wr_idx;
  // Full beats 0..NBEATS-2 and the narrow final beat are kept apart, so the
  // unused upper bits of the last beat never get storage.
  logic [NBEATS-2:0][BEAT_W-1:0]   r_body;
  logic [LAST_W-1:0]               r_tail;

  // A beat can be taken in IDLE and FILL. During reset in_ready is held low.
  assign in_ready  = (r_state != HOLD) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign vec_valid = (r_state == HOLD);
  assign frame_err = r_frame_err;
  assign beat_cnt  = r_beat_cnt;
  assign vec_o     = {r_tail, r_body};

  // State, beat index and error pulse registers.
  // NOTE: clocked state uses non-blocking assignments, so every register
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_beat_cnt  <= 5'd0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  // Next-state, framing checks and beat write strobe.
  // NOTE: each output gets a default first, so a path that assigns nothing
  // still has a defined value and no latch is inferred.
  always_comb begin
    w_state_nxt     = r_state;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_frame_err_nxt = 1'b0;
    w_wr_en         = 1'b0;
    w_wr_idx        = r_beat_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (in_first && !in_last) begin
            w_wr_en        = 1'b1;
            w_wr_idx       = 5'd0;
            w_beat_cnt_nxt = 5'd1;
            w_state_nxt    = FILL;
          end else begin
            // A stray beat, or a single-beat first+last frame, is dropped.
            w_frame_err_nxt = 1'b1;
          end
        end
      end
      FILL: begin
        if (w_accept) begin
          if (in_first && in_last) begin
            w_frame_err_nxt = 1'b1;
            w_beat_cnt_nxt  = 5'd0;
            w_state_nxt     = IDLE;
          end else if (in_first) begin
            // Restart: drop the partial frame and take this beat as beat 0.
            w_frame_err_nxt = 1'b1;
            w_wr_en         = 1'b1;
            w_wr_idx        = 5'd0;
            w_beat_cnt_nxt  = 5'd1;
          end else if (r_beat_cnt == LAST_IDX) begin
            if (in_last) begin
              w_wr_en     = 1'b1;
              w_state_nxt = HOLD;
            end else begin
              w_frame_err_nxt = 1'b1;
              w_beat_cnt_nxt  = 5'd0;
              w_state_nxt     = IDLE;
            end
          end else if (in_last) begin
            w_frame_err_nxt = 1'b1;
            w_beat_cnt_nxt  = 5'd0;
            w_state_nxt     = IDLE;
          end else begin
            w_wr_en        = 1'b1;
            w_beat_cnt_nxt = r_beat_cnt + 5'd1;
          end
        end
      end
      HOLD: begin
        if (vec_ready) begin
          w_beat_cnt_nxt = 5'd0;
          w_state_nxt    = IDLE;
        end
      end
      default: begin
        w_beat_cnt_nxt = 5'd0;
        w_state_nxt    = IDLE;
      end
    endcase
  end

  // Vector storage: the selected beat slot is written on an accepted beat.
  // NOTE: the vector storage is reset on purpose, because the block must
  // present vec_o as all zeros out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_body <= '0;
      r_tail <= '0;
    end else if (w_wr_en) begin
      if (w_wr_idx == LAST_IDX) begin
        r_tail <= in_data[LAST_W-1:0];
      end else begin
        r_body[w_wr_idx] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_input_vector_assembler.sv
// tb_input_vector_assembler
// Directed bench for input_vector_assembler. Inputs are driven 1 ns after the
// rising edge, and outputs are checked at the same point, away from the edge.
module tb_input_vector_assembler;

  localparam int VEC_W  = 1894;
  localparam int BEAT_W = 64;
  localparam int NBEATS = 30;

  logic              clk;
  logic              rst;
  logic [BEAT_W-1:0] in_data;
  logic              in_first;
  logic              in_last;
  logic              in_valid;
  logic              in_ready;
  logic [VEC_W-1:0]  vec_o;
  logic              vec_valid;
  logic              vec_ready;
  logic              frame_err;
  logic [4:0]        beat_cnt;

  int n_cmp;
  int n_bad;
  int n_err_pulses;
  int err_base;
  logic [VEC_W-1:0] exp_vec;

  input_vector_assembler #(.VEC_W(VEC_W), .BEAT_W(BEAT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vec_o     (vec_o),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .frame_err (frame_err),
    .beat_cnt  (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_err pulses. A one-cycle pulse is seen at exactly one falling edge.
  always @(negedge clk) if (frame_err === 1'b1) n_err_pulses++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Beat k of test frame s. Frame 0 is the nominal pattern.
  function automatic logic [63:0] beat_word(input int s, input int k);
    return {32'hA5A5_0000 + 32'(k) + 32'(s << 8), 32'(k) + 32'(s << 16)};
  endfunction

  function automatic logic [VEC_W-1:0] frame_vec(input int s);
    logic [VEC_W-1:0] v;
    logic [63:0]      w;
    v = '0;
    for (int b = 0; b < VEC_W; b++) begin
      w    = beat_word(s, b / BEAT_W);
      v[b] = w[b % BEAT_W];
    end
    return v;
  endfunction

  // One beat, after 'gap' idle cycles. Returns 1 ns after the accepting edge.
  task automatic drive_beat(input logic [63:0] d, input logic f, input logic l, input int gap);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_data  = d;
    in_first = f;
    in_last  = l;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  // Beats 0..n-1 of frame s, with in_last on beat last_at (-1 means never).
  task automatic send_beats(input int s, input int n, input int last_at, input int gap_max);
    for (int k = 0; k < n; k++) begin
      if (k == n - 1) check("vec_valid_before_last_beat", 64'(vec_valid), 64'd0);
      drive_beat(beat_word(s, k), k == 0, k == last_at, $urandom_range(0, gap_max));
    end
  endtask

  task automatic check_frame(input string tag, input int s);
    exp_vec = frame_vec(s);
    check({tag, "_vec_valid"}, 64'(vec_valid), 64'd1);
    check({tag, "_vec_o_match"}, 64'(vec_o === exp_vec), 64'd1);
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    n_err_pulses = 0;
    rst       = 1'b1;
    in_data   = '0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    in_valid  = 1'b0;
    vec_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_vec_valid", 64'(vec_valid), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    check("rst_vec_o_zero", 64'(vec_o === '0), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Nominal frame with vec_ready held high.
    err_base = n_err_pulses;
    send_beats(0, NBEATS, NBEATS - 1, 0);
    check_frame("nominal", 0);
    check("nominal_low_beat", vec_o[63:0], 64'hA5A5_0000_0000_0000);
    check("nominal_top_38", 64'(vec_o[1893:1856]), 64'h1D_0000_001D);
    check("nominal_in_ready_hold", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("nominal_valid_clears", 64'(vec_valid), 64'd0);
    check("nominal_in_ready_back", 64'(in_ready), 64'd1);
    check("nominal_no_err", 64'(n_err_pulses - err_base), 64'd0);

    // Backpressure: vector held for 10 cycles while a beat is offered.
    vec_ready = 1'b0;
    send_beats(1, NBEATS, NBEATS - 1, 0);
    check_frame("bp", 1);
    in_data  = 64'hDEAD_BEEF_0000_0001;
    in_first = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", 64'(vec_valid), 64'd1);
      check("bp_hold_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold_vec_o", 64'(vec_o === exp_vec), 64'd1);
    end
    in_valid  = 1'b0;
    in_first  = 1'b0;
    vec_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 64'(vec_valid), 64'd0);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_beat_cnt", 64'(beat_cnt), 64'd0);
    send_beats(2, NBEATS, NBEATS - 1, 0);
    check_frame("bp_next", 2);
    @(posedge clk);
    #1;

    // Early last on beat 12, then a good frame.
    err_base = n_err_pulses;
    send_beats(3, 13, 12, 0);
    check("early_last_err", 64'(frame_err), 64'd1);
    check("early_last_beat_cnt", 64'(beat_cnt), 64'd0);
    check("early_last_valid", 64'(vec_valid), 64'd0);
    send_beats(4, NBEATS, NBEATS - 1, 0);
    check_frame("after_early", 4);
    check("early_last_pulses", 64'(n_err_pulses - err_base), 64'd1);
    @(posedge clk);
    #1;

    // Restart: in_first reasserted where beat 7 was due.
    err_base = n_err_pulses;
    send_beats(5, 7, -1, 0);
    check("restart_cnt_before", 64'(beat_cnt), 64'd7);
    send_beats(6, NBEATS, NBEATS - 1, 0);
    check_frame("restart", 6);
    check("restart_pulses", 64'(n_err_pulses - err_base), 64'd1);
    @(posedge clk);
    #1;

    // Missing last on beat 29, then a stray beat straight after it.
    err_base = n_err_pulses;
    send_beats(7, NBEATS, -1, 0);
    check("missing_last_err", 64'(frame_err), 64'd1);
    check("missing_last_beat_cnt", 64'(beat_cnt), 64'd0);
    check("missing_last_valid", 64'(vec_valid), 64'd0);
    drive_beat(64'h1234, 1'b0, 1'b0, 0);
    check("stray_err", 64'(frame_err), 64'd1);
    check("stray_beat_cnt", 64'(beat_cnt), 64'd0);
    @(posedge clk);
    #1;
    check("stray_err_clears", 64'(frame_err), 64'd0);
    check("missing_stray_pulses", 64'(n_err_pulses - err_base), 64'd2);

    // Async reset after beat 15, with random in_valid gaps.
    send_beats(8, 16, -1, 2);
    check("pre_rst_beat_cnt", 64'(beat_cnt), 64'd16);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_beat_cnt", 64'(beat_cnt), 64'd0);
    check("async_rst_valid", 64'(vec_valid), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd0);
    check("async_rst_vec_o_zero", 64'(vec_o === '0), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_beats(9, NBEATS, NBEATS - 1, 2);
    check_frame("after_rst", 9);
    @(posedge clk);
    #1;
    check("after_rst_valid_clears", 64'(vec_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/input_vector_assembler.md
Name: input_vector_assembler

Overview:
- Builds the wide input snapshot that the learned per-bit output modules of the CPU cluster consume, as a 1894-bit bus `i`.
- Snapshot arrives as a stream of narrow beats from the capture/replay path; the block packs them LSB-first, checks framing, and presents one complete vector with a valid/ready handshake.
- It is the producer end of the snapshot interface that the per-bit modules read.

Parameters:
- VEC_W, 1894, width of the assembled snapshot vector.
- BEAT_W, 64, width of one input beat.
- NBEATS, ceil(VEC_W/BEAT_W) = 30, beats per vector (derived; not overridable).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  BEAT_W  beat payload; beat k carries vector bits [k*BEAT_W +: BEAT_W].
- in_first  input  1  marks beat 0 of a vector.
- in_last  input  1  marks beat NBEATS-1.
- in_valid  input  1  beat present.
- in_ready  output  1  block accepts beat this cycle.
- vec_o  output  VEC_W  assembled snapshot, stable while vec_valid=1.
- vec_valid  output  1  vec_o complete and framed correctly.
- vec_ready  input  1  consumer takes vector.
- frame_err  output  1  one-cycle pulse on framing violation.
- beat_cnt  output  5  index of next expected beat (debug).

Behaviour:
- Reset (async assert, sync release): state=IDLE, beat_cnt=0, in_ready=0 during reset then 1, vec_valid=0, frame_err=0, vec_o=0.
- A beat is accepted when in_valid & in_ready.
- States:
  - IDLE: in_ready=1.
    - Accepted beat with in_first=1: write beat 0, beat_cnt=1, go FILL.
    - Accepted beat with in_first=0: discard it, pulse frame_err, stay IDLE.
  - FILL: in_ready=1. Accepted beat at index beat_cnt writes vec_o[beat_cnt*BEAT_W +: BEAT_W].
    - Beat NBEATS-1 writes only the low VEC_W-(NBEATS-1)*BEAT_W = 38 bits; upper 26 in_data bits are ignored.
    - Accepted beat with in_first=1: pulse frame_err, drop partial, treat the beat as a new beat 0, beat_cnt=1, stay FILL.
    - in_last=1 at beat_cnt != NBEATS-1: pulse frame_err, discard, go IDLE, beat_cnt=0.
    - beat_cnt == NBEATS-1 with in_last=0: pulse frame_err, discard, go IDLE, beat_cnt=0.
    - beat_cnt == NBEATS-1 with in_last=1: write, go HOLD, vec_valid=1 next cycle.
  - HOLD: vec_valid=1, in_ready=0, vec_o frozen.
    - vec_ready=1: vec_valid drops next cycle, go IDLE, beat_cnt=0.
    - vec_valid never drops without vec_ready.
- Latency: vec_valid rises the cycle after the last beat is accepted. Minimum vector period is NBEATS+1 cycles, since HOLD consumes at least one cycle.
- vec_o bits not yet written in a partial frame hold stale data and are never exposed with vec_valid=1.
- A beat with in_first=1 and in_last=1 is a framing error whenever NBEATS>1.
- frame_err is registered: high exactly the cycle after the offending beat. Back-to-back errors give back-to-back pulses.
- beat_cnt wraps only through the transitions listed above; it never exceeds NBEATS-1.
- Reset asserted mid-FILL or in HOLD: immediate return to the reset values; the partial or held vector is lost.
- in_valid=0 cycles inside FILL stall assembly; the block has no timeout.

Test Plan:
- Nominal frame: 30 beats, beat k data = {32'hA5A5_0000+k, 32'h0000_0000+k}, in_first on beat 0, in_last on beat 29, vec_ready=1 -> vec_valid=1 exactly one cycle after beat 29. vec_o[63:0] = beat 0. vec_o[1893:1856] = beat 29 bits [37:0]. vec_valid clears the next cycle. frame_err never pulses.
- Backpressure: vec_ready=0 for 10 cycles after a complete frame -> vec_valid holds 1, in_ready=0, vec_o unchanged, offered beats are not accepted. Releasing vec_ready -> in_ready=1 one cycle later, and the next frame assembles correctly.
- Early last: in_last on beat 12 -> frame_err pulses once, vec_valid stays 0, state IDLE. A following correct frame is delivered intact.
- Restart mid-frame: in_first reasserted on beat 7 followed by a full 30-beat frame -> one frame_err pulse, then the delivered vec_o matches the second frame only.
- Missing last, plus stray beat: beat 29 sent with in_last=0 -> frame_err, IDLE. A subsequent beat with in_first=0 in IDLE -> second frame_err pulse, beat_cnt=0.
- Async reset at beat 15 with random in_valid gaps -> vec_valid=0, beat_cnt=0 immediately, without waiting for a clock edge. After release, a full frame assembles correctly with a latency of 1 cycle after the last beat.
